// File: rtl/fpu_issue_sched_pkg.sv
// Shared definitions for the FPU issue scheduler: op-class encodings,
// forwarding select encodings, FSM state codes and default latencies.
package fpu_issue_sched_pkg;

  typedef enum logic [2:0] {
    FPU_SEL_ADD     = 3'd0,
    FPU_SEL_SUB     = 3'd1,
    FPU_SEL_MUL     = 3'd2,
    FPU_SEL_MADD    = 3'd3,
    FPU_SEL_SIMPLE  = 3'd4,
    FPU_SEL_CVT     = 3'd5,
    FPU_SEL_SIMPLE6 = 3'd6,
    FPU_SEL_SIMPLE7 = 3'd7
  } fpu_sel_e;

  // Operand source selects: register file read or forwarded FPU result.
  localparam logic FP_REG_SEL = 1'b0;
  localparam logic FP_A_FWD   = 1'b1;
  localparam logic FP_B_FWD   = 1'b1;
  localparam logic FP_C_FWD   = 1'b1;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_EXEC = 1'b1;

  localparam int LAT_ADD_DEF    = 3;
  localparam int LAT_MUL_DEF    = 3;
  localparam int LAT_MADD_DEF   = 5;
  localparam int LAT_CVT_DEF    = 2;
  localparam int LAT_SIMPLE_DEF = 1;
  localparam int CNT_W_DEF      = 3;

  function automatic logic fwd_hit(input logic wb_valid, input logic use_src,
                                   input logic [4:0] rs, input logic [4:0] rd);
    return wb_valid & use_src & (rs == rd);
  endfunction

endpackage

// File: rtl/fpu_issue_sched_if.sv
// Decode-to-scheduler bus: FP issue request in, FPU control and forwarding out.
interface fpu_issue_sched_if;
  logic       issue_valid;
  logic [2:0] issue_op;
  logic [4:0] issue_rd;
  logic [4:0] issue_rs1;
  logic [4:0] issue_rs2;
  logic [4:0] issue_rs3;
  logic       issue_use1;
  logic       issue_use2;
  logic       issue_use3;
  logic       issue_kill;
  logic       fpu_valid;
  logic       stall;
  logic       busy;
  logic       almost_done;
  logic       wb_valid;
  logic [4:0] wb_rd;
  logic       fwd_a;
  logic       fwd_b;
  logic       fwd_c;

  modport master (
    output issue_valid, issue_op, issue_rd, issue_rs1, issue_rs2, issue_rs3,
           issue_use1, issue_use2, issue_use3, issue_kill,
    input  fpu_valid, stall, busy, almost_done, wb_valid, wb_rd,
           fwd_a, fwd_b, fwd_c
  );

  modport slave (
    input  issue_valid, issue_op, issue_rd, issue_rs1, issue_rs2, issue_rs3,
           issue_use1, issue_use2, issue_use3, issue_kill,
    output fpu_valid, stall, busy, almost_done, wb_valid, wb_rd,
           fwd_a, fwd_b, fwd_c
  );
endinterface

// File: rtl/fpu_issue_sched_lat_lut.sv
// Op-class to FPU latency map; the single place to edit when FPU pipeline depth changes.
module fpu_lat_lut
  import fpu_issue_sched_pkg::*;
#(
  parameter int LAT_ADD    = LAT_ADD_DEF,
  parameter int LAT_MUL    = LAT_MUL_DEF,
  parameter int LAT_MADD   = LAT_MADD_DEF,
  parameter int LAT_CVT    = LAT_CVT_DEF,
  parameter int LAT_SIMPLE = LAT_SIMPLE_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic [2:0]       op,
  output logic [CNT_W-1:0] lat
);

  // Decode op class into its result latency.
  always_comb begin
    lat = CNT_W'(LAT_SIMPLE);
    case (fpu_sel_e'(op))
      FPU_SEL_ADD, FPU_SEL_SUB:                        lat = CNT_W'(LAT_ADD);
      FPU_SEL_MUL:                                     lat = CNT_W'(LAT_MUL);
      FPU_SEL_MADD:                                    lat = CNT_W'(LAT_MADD);
      FPU_SEL_CVT:                                     lat = CNT_W'(LAT_CVT);
      FPU_SEL_SIMPLE, FPU_SEL_SIMPLE6, FPU_SEL_SIMPLE7: lat = CNT_W'(LAT_SIMPLE);
      default:                                         lat = CNT_W'(LAT_SIMPLE);
    endcase
  end

endmodule

// File: rtl/fpu_issue_sched.sv
// Execute-stage FPU sequencer: single op in flight, latency counting, stall,
// writeback pulse and same-cycle operand forwarding selects.
module fpu_issue_sched
  import fpu_issue_sched_pkg::*;
#(
  parameter int LAT_ADD    = LAT_ADD_DEF,
  parameter int LAT_MUL    = LAT_MUL_DEF,
  parameter int LAT_MADD   = LAT_MADD_DEF,
  parameter int LAT_CVT    = LAT_CVT_DEF,
  parameter int LAT_SIMPLE = LAT_SIMPLE_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input logic              clk,
  input logic              rst,
  fpu_issue_sched_if.slave io
);

  logic [0:0]       state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [4:0]       pend_rd_r;
  logic             pend_valid_r;
  logic             wb_valid_r;
  logic [4:0]       wb_rd_r;

  logic [CNT_W-1:0] lat_s;
  logic             lat_one_s;
  logic             busy_s;
  logic             stall_s;
  logic             accept_s;

  fpu_lat_lut #(
    .LAT_ADD    (LAT_ADD),
    .LAT_MUL    (LAT_MUL),
    .LAT_MADD   (LAT_MADD),
    .LAT_CVT    (LAT_CVT),
    .LAT_SIMPLE (LAT_SIMPLE),
    .CNT_W      (CNT_W)
  ) u_lat_lut (
    .op  (io.issue_op),
    .lat (lat_s)
  );

  assign lat_one_s = (lat_s == CNT_W'(1));
  assign busy_s    = (state_r == ST_EXEC);
  // Kill is only honoured for the presented op; an in-flight op is older than the flush.
  assign stall_s   = io.issue_valid & busy_s;
  assign accept_s  = io.issue_valid & ~io.issue_kill & ~stall_s;

  // Sequencer state, latency counter and registered writeback.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      cnt_r        <= {CNT_W{1'b0}};
      pend_rd_r    <= 5'd0;
      pend_valid_r <= 1'b0;
      wb_valid_r   <= 1'b0;
      wb_rd_r      <= 5'd0;
    end else begin
      wb_valid_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            pend_rd_r <= io.issue_rd;
            if (lat_one_s) begin
              wb_valid_r   <= 1'b1;
              wb_rd_r      <= io.issue_rd;
              pend_valid_r <= 1'b0;
            end else begin
              state_r      <= ST_EXEC;
              cnt_r        <= lat_s - CNT_W'(1);
              pend_valid_r <= 1'b1;
            end
          end
        end
        ST_EXEC: begin
          cnt_r <= cnt_r - CNT_W'(1);
          if (cnt_r == CNT_W'(1)) begin
            state_r      <= ST_IDLE;
            wb_valid_r   <= pend_valid_r;
            wb_rd_r      <= pend_rd_r;
            pend_valid_r <= 1'b0;
          end
        end
        default: begin
          state_r      <= ST_IDLE;
          pend_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign io.fpu_valid   = accept_s;
  assign io.stall       = stall_s;
  assign io.busy        = busy_s;
  assign io.almost_done = busy_s & (cnt_r == CNT_W'(1));
  assign io.wb_valid    = wb_valid_r;
  assign io.wb_rd       = wb_rd_r;

  // The completing result is consumable by the op presented in its writeback cycle.
  assign io.fwd_a = fwd_hit(wb_valid_r, io.issue_use1, io.issue_rs1, wb_rd_r) ? FP_A_FWD : FP_REG_SEL;
  assign io.fwd_b = fwd_hit(wb_valid_r, io.issue_use2, io.issue_rs2, wb_rd_r) ? FP_B_FWD : FP_REG_SEL;
  assign io.fwd_c = fwd_hit(wb_valid_r, io.issue_use3, io.issue_rs3, wb_rd_r) ? FP_C_FWD : FP_REG_SEL;

endmodule
